// File: rtl/csi2_packet_decoder.sv
// CSI-2 packet layer: header ECC check, virtual-channel filter, short-packet
// sync decode and RAW8 long-packet payload forwarding (mipi_clk domain).
module csi2_packet_decoder #(
  parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0,
  parameter logic [5:0] DATA_TYPE       = 6'h2A
) (
  input  logic            mipi_clk,
  input  logic            reset_n,
  input  logic            lane_valid,
  input  logic [3:0][7:0] lane_data,
  output logic            mipi_data_enable,
  output logic [3:0][7:0] mipi_data,
  output logic [3:0]      mipi_byte_valid,
  output logic            interrupt,
  output logic            frame_start,
  output logic            frame_end,
  output logic            line_start,
  output logic            line_end,
  output logic            ecc_error,
  output logic            truncated
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PAYLOAD = 2'd1,
    S_DRAIN   = 2'd2
  } state_t;

  // Six Hamming parity bits over {WC, DI}; each bit is the XOR of a fixed
  // subset of the 24 header data bits.
  function automatic logic [5:0] ecc_parity(input logic [23:0] d);
    logic [5:0] p;
    p[0] = ^(d & 24'hF12CB7);
    p[1] = ^(d & 24'hF2555B);
    p[2] = ^(d & 24'h749A6D);
    p[3] = ^(d & 24'hB8E38E);
    p[4] = ^(d & 24'hDF03F0);
    p[5] = ^(d & 24'hEFFC00);
    return p;
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [15:0]     r_remaining;
  logic [15:0]     w_remaining_nxt;
  logic            r_seen_idle;

  logic [7:0]      w_di;
  logic [15:0]     w_wc;
  logic [7:0]      w_ecc;
  logic [5:0]      w_parity;
  logic            w_ecc_ok;

  logic            w_en;
  logic [3:0][7:0] w_data;
  logic [3:0]      w_bv;
  logic            w_int;
  logic            w_fs;
  logic            w_fe;
  logic            w_ls;
  logic            w_le;
  logic            w_ecc_err;
  logic            w_trunc;

  assign w_di     = lane_data[0];
  assign w_wc     = {lane_data[2], lane_data[1]};
  assign w_ecc    = lane_data[3];
  assign w_parity = ecc_parity({w_wc, w_di});
  assign w_ecc_ok = (w_ecc[7:6] == 2'b00) && (w_ecc[5:0] == w_parity);

  // Next-state, remaining-byte count and next output values.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    w_en            = 1'b0;
    w_data          = '0;
    w_bv            = '0;
    w_int           = 1'b0;
    w_fs            = 1'b0;
    w_fe            = 1'b0;
    w_ls            = 1'b0;
    w_le            = 1'b0;
    w_ecc_err       = 1'b0;
    w_trunc         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (lane_valid && r_seen_idle) begin
          w_state_nxt = S_DRAIN;
          if (!w_ecc_ok) begin
            w_ecc_err = 1'b1;
          end else if (w_di[7:6] == VIRTUAL_CHANNEL) begin
            w_int = 1'b1;
            if (w_di[5:0] < 6'h10) begin
              case (w_di[5:0])
                6'h00:   w_fs = 1'b1;
                6'h01:   w_fe = 1'b1;
                6'h02:   w_ls = 1'b1;
                6'h03:   w_le = 1'b1;
                default: ;
              endcase
            end else if ((w_di[5:0] == DATA_TYPE) && (w_wc != 16'd0)) begin
              w_remaining_nxt = w_wc;
              w_state_nxt     = S_PAYLOAD;
            end
          end
        end
      end
      S_PAYLOAD: begin
        if (lane_valid) begin
          w_en   = 1'b1;
          w_data = lane_data;
          if (r_remaining >= 16'd4) begin
            w_bv            = 4'b1111;
            w_remaining_nxt = r_remaining - 16'd4;
          end else begin
            case (r_remaining[1:0])
              2'd1:    w_bv = 4'b0001;
              2'd2:    w_bv = 4'b0011;
              2'd3:    w_bv = 4'b0111;
              default: w_bv = 4'b0000;
            endcase
            w_remaining_nxt = '0;
          end
          if (r_remaining <= 16'd4) begin
            w_state_nxt = S_DRAIN;
          end
        end else begin
          w_trunc         = 1'b1;
          w_remaining_nxt = '0;
          w_state_nxt     = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (!lane_valid) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_remaining_nxt = '0;
      end
    endcase
  end

  // State and payload byte counter.
  always_ff @(posedge mipi_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Headers are only trusted after an LP gap has been observed since reset,
  // so a packet cut in half by reset is never misread mid-stream.
  always_ff @(posedge mipi_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_seen_idle <= 1'b0;
    end else if (!lane_valid) begin
      r_seen_idle <= 1'b1;
    end
  end

  // Registered outputs.
  always_ff @(posedge mipi_clk or negedge reset_n) begin
    if (!reset_n) begin
      mipi_data_enable <= 1'b0;
      mipi_data        <= '0;
      mipi_byte_valid  <= '0;
      interrupt        <= 1'b0;
      frame_start      <= 1'b0;
      frame_end        <= 1'b0;
      line_start       <= 1'b0;
      line_end         <= 1'b0;
      ecc_error        <= 1'b0;
      truncated        <= 1'b0;
    end else begin
      mipi_data_enable <= w_en;
      mipi_data        <= w_data;
      mipi_byte_valid  <= w_bv;
      interrupt        <= w_int;
      frame_start      <= w_fs;
      frame_end        <= w_fe;
      line_start       <= w_ls;
      line_end         <= w_le;
      ecc_error        <= w_ecc_err;
      truncated        <= w_trunc;
    end
  end

endmodule
